// File: rtl/lut_bitserial_acc_pkg.sv
// Shared definitions for the LUT mux, weight fetch and bit-serial accumulator.
// Holds datapath widths, the precision encoding and the accumulator FSM states.
package lut_bitserial_acc_pkg;

    localparam int IN_W     = 16;
    localparam int MAX_BITS = 16;
    localparam int ACC_W    = 32;
    localparam int WIN_W    = 8;

    // Weight precision stored as (bit planes - 1)
    typedef logic [3:0] prec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/lut_bitserial_acc_if.sv
// Job control, partial-sum input and result output bundle of the accumulator.
// The master side is the job issuer / LUT mux / result consumer, the slave side is the accumulator.
interface lut_bitserial_acc_if #(
    parameter int IN_W  = lut_bitserial_acc_pkg::IN_W,
    parameter int ACC_W = lut_bitserial_acc_pkg::ACC_W,
    parameter int WIN_W = lut_bitserial_acc_pkg::WIN_W
);
    logic                              start;
    lut_bitserial_acc_pkg::prec_t      prec_m1;
    logic                              signed_w;
    logic [WIN_W-1:0]                  num_win;
    logic [IN_W-1:0]                   psum;
    logic                              psum_valid;
    logic                              psum_ready;
    lut_bitserial_acc_pkg::prec_t      plane_idx;
    logic [ACC_W-1:0]                  res;
    logic                              res_valid;
    logic                              res_ready;
    logic                              busy;
    logic                              done;

    modport master (
        output start, prec_m1, signed_w, num_win, psum, psum_valid, res_ready,
        input  psum_ready, plane_idx, res, res_valid, busy, done
    );

    modport slave (
        input  start, prec_m1, signed_w, num_win, psum, psum_valid, res_ready,
        output psum_ready, plane_idx, res, res_valid, busy, done
    );
endinterface

// File: rtl/lut_bitserial_acc_shift.sv
// Shift-and-add datapath: folds one sign-extended partial sum per bit plane into the accumulator.
// The first (MSB) plane loads the accumulator directly, negated for two's complement weights.
module bs_shift_acc #(
    parameter int IN_W  = lut_bitserial_acc_pkg::IN_W,
    parameter int ACC_W = lut_bitserial_acc_pkg::ACC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    first,
    input  logic                    signed_w,
    input  logic [IN_W-1:0]         psum,
    input  logic                    en,
    input  logic                    clr,
    output logic signed [ACC_W-1:0] acc_next
);
    logic signed [ACC_W-1:0] w_psum_ext;
    logic signed [ACC_W-1:0] r_acc;

    assign w_psum_ext = {{(ACC_W-IN_W){psum[IN_W-1]}}, psum};

    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves it unassigned would infer a latch.
    always_comb begin
        acc_next = (r_acc <<< 1) + w_psum_ext;
        if (first) begin
            acc_next = signed_w ? -w_psum_ext : w_psum_ext;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= acc_next;
        end
    end
endmodule

// File: rtl/lut_bitserial_acc.sv
// Bit-serial shift-and-accumulate stage behind the 8-to-1 LUT mux, MSB plane first.
// Sequences PREC planes per window and emits one result per window over valid/ready.
module lut_bitserial_acc #(
    parameter int IN_W     = lut_bitserial_acc_pkg::IN_W,
    parameter int MAX_BITS = lut_bitserial_acc_pkg::MAX_BITS,
    parameter int ACC_W    = lut_bitserial_acc_pkg::ACC_W,
    parameter int WIN_W    = lut_bitserial_acc_pkg::WIN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lut_bitserial_acc_if.slave   bus
);
    import lut_bitserial_acc_pkg::*;

    localparam int IDX_W = $clog2(MAX_BITS);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IDX_W-1:0]        r_prec;
    logic [IDX_W-1:0]        r_plane_idx;
    logic                    r_signed;
    logic [WIN_W-1:0]        r_num_win;
    logic [WIN_W-1:0]        r_win_cnt;
    logic signed [ACC_W-1:0] r_res;
    logic                    r_res_valid;
    logic                    r_done;

    logic                    w_psum_ready;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_final_win;
    logic                    w_first;
    logic                    w_start_job;
    logic                    w_done_set;
    logic signed [ACC_W-1:0] w_acc_next;

    // The last plane may only land if the single output slot is free or draining this cycle
    assign w_psum_ready = (r_state == RUN) &&
                          !((r_plane_idx == '0) && r_res_valid && !bus.res_ready);
    assign w_accept     = w_psum_ready && bus.psum_valid;
    assign w_last       = w_accept && (r_plane_idx == '0);
    assign w_first      = (r_plane_idx == r_prec);
    assign w_final_win  = (r_win_cnt == r_num_win - WIN_W'(1));
    assign w_start_job  = (r_state == IDLE) && bus.start && (bus.num_win != '0);

    always_comb begin
        w_state_next = r_state;
        w_done_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && (bus.num_win == '0)) begin
                    w_done_set = 1'b1;
                end else if (w_start_job) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last && w_final_win) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (!r_res_valid || bus.res_ready) begin
                    w_done_set   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prec      <= '0;
            r_signed    <= 1'b0;
            r_num_win   <= '0;
            r_plane_idx <= '0;
            r_win_cnt   <= '0;
        end else if (w_start_job) begin
            r_prec      <= bus.prec_m1;
            r_signed    <= bus.signed_w;
            r_num_win   <= bus.num_win;
            r_plane_idx <= bus.prec_m1;
            r_win_cnt   <= '0;
        end else if (w_accept) begin
            r_plane_idx <= w_last ? r_prec : r_plane_idx - IDX_W'(1);
            if (w_last) begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res       <= '0;
            r_res_valid <= 1'b0;
        end else if (w_last) begin
            r_res       <= w_acc_next;
            r_res_valid <= 1'b1;
        end else if (r_res_valid && bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    bs_shift_acc #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_shift_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .first    (w_first),
        .signed_w (r_signed),
        .psum     (bus.psum),
        .en       (w_accept),
        .clr      (w_start_job || w_last),
        .acc_next (w_acc_next)
    );

    assign bus.psum_ready = w_psum_ready;
    assign bus.plane_idx  = r_plane_idx;
    assign bus.res        = r_res;
    assign bus.res_valid  = r_res_valid;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
endmodule
